// File: rtl/addsub_cla_reg_pkg.sv
// Lookahead group width shared by the adder top level and its 4-bit carry block.
package addsub_cla_reg_pkg;
  localparam int GROUP_W = 4;
endpackage

// File: rtl/addsub_cla_reg_cla_group4.sv
// Lookahead block for one 4-bit group: internal carries, group generate and group propagate.
module cla_group4
  import addsub_cla_reg_pkg::*;
(
  input  logic [GROUP_W-1:0] i_g,
  input  logic [GROUP_W-1:0] i_p,
  input  logic               i_c,
  output logic [GROUP_W-1:1] o_c,
  output logic               o_g,
  output logic               o_p
);

  // Each carry is a flat sum of products of the carry-in, so no carry depends on another.
  assign o_c[1] = i_g[0] | (i_p[0] & i_c);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);

  assign o_g = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
             | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_p = &i_p;

endmodule

// File: rtl/addsub_cla_reg.sv
// Registered W-bit two's-complement adder/subtractor built from 4-bit lookahead groups
// with a second-level lookahead across groups; S, C and V are captured together each clock.
module addsub_cla_reg
  import addsub_cla_reg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         M,
  output logic [W-1:0] S,
  output logic         C,
  output logic         V
);

  localparam int NG = (W + GROUP_W - 1) / GROUP_W;
  localparam int PW = NG * GROUP_W;

  logic [W-1:0]  w_bx;
  logic [W-1:0]  w_g;
  logic [W-1:0]  w_p;
  logic [PW-1:0] w_g_pad;
  logic [PW-1:0] w_p_pad;
  logic [NG-1:0] w_grp_g;
  logic [NG-1:0] w_grp_p;
  logic [NG:0]   w_gc;
  logic [W:0]    w_c;
  logic [W-1:0]  w_s;
  logic          w_cout;
  logic          w_ovf;

  logic [W-1:0]  r_s;
  logic          r_c;
  logic          r_v;

  // Subtraction is A + ~B + 1: invert B under M and feed M in as carry-in.
  assign w_bx = B ^ {W{M}};
  assign w_g  = A & w_bx;
  assign w_p  = A ^ w_bx;

  // Bits of a partial top group are padded with g = p = 0.
  assign w_g_pad = PW'(w_g);
  assign w_p_pad = PW'(w_p);

  // Group carries are expanded into flat products so no group waits on the one below.
  always_comb begin
    logic w_acc;
    logic w_term;
    w_gc    = '0;
    w_acc   = 1'b0;
    w_term  = 1'b0;
    w_gc[0] = M;
    for (int k = 1; k <= NG; k++) begin
      w_acc = M;
      for (int l = 0; l < k; l++) w_acc = w_acc & w_grp_p[l];
      for (int j = 0; j < k; j++) begin
        w_term = w_grp_g[j];
        for (int l = j + 1; l < k; l++) w_term = w_term & w_grp_p[l];
        w_acc = w_acc | w_term;
      end
      w_gc[k] = w_acc;
    end
  end

  for (genvar gk = 0; gk < NG; gk++) begin : g_grp
    logic [GROUP_W-1:1] w_ci;

    cla_group4 u_grp (
      .i_g (w_g_pad[gk*GROUP_W +: GROUP_W]),
      .i_p (w_p_pad[gk*GROUP_W +: GROUP_W]),
      .i_c (w_gc[gk]),
      .o_c (w_ci),
      .o_g (w_grp_g[gk]),
      .o_p (w_grp_p[gk])
    );

    assign w_c[gk*GROUP_W] = w_gc[gk];
    for (genvar bi = 1; bi < GROUP_W; bi++) begin : g_bit
      if (gk*GROUP_W + bi <= W) begin : g_used
        assign w_c[gk*GROUP_W + bi] = w_ci[bi];
      end
    end
  end

  // With a partial top group, c_W is one of that group's internal carries instead.
  if (W % GROUP_W == 0) begin : g_full_top
    assign w_c[W] = w_gc[NG];
  end

  assign w_s    = w_p ^ w_c[W-1:0];
  assign w_cout = w_c[W];
  assign w_ovf  = w_c[W] ^ w_c[W-1];

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so S, C and V
  // always come from the same operand set regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_s <= w_s;
      r_c <= w_cout;
      r_v <= w_ovf;
    end
  end

  assign S = r_s;
  assign C = r_c;
  assign V = r_v;

endmodule

// File: tb/tb_addsub_cla_reg.sv
// Self-checking bench: directed W=4 vectors, reset and hold sequences, and exhaustive
// sweeps at W=4 and W=6 against an arithmetic reference model.
module tb_addsub_cla_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] a4, b4, s4;
  logic       m4, c4, v4;
  logic [5:0] a6, b6, s6;
  logic       m6, c6, v6;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[10];

  addsub_cla_reg #(.W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a4),
    .B     (b4),
    .M     (m4),
    .S     (s4),
    .C     (c4),
    .V     (v4)
  );

  addsub_cla_reg #(.W(6)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a6),
    .B     (b6),
    .M     (m6),
    .S     (s6),
    .C     (c6),
    .V     (v6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum of A and the effective operand, plus the signed true result for V.
  function automatic void model(input int w, input int a, input int b, input int m,
                                output int s, output int c, output int v);
    int mask, half, bx, sum, sa, sb, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    bx   = (m != 0) ? (~b & mask) : b;
    sum  = a + bx + m;
    s    = sum & mask;
    c    = (sum >> w) & 1;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    r    = (m != 0) ? sa - sb : sa + sb;
    v    = (r < -half || r >= half) ? 1 : 0;
  endfunction

  initial begin
    int es, ec, ev;
    n_checks = 0;
    n_errors = 0;

    //              A      B     M     S      C     V
    vecs[0] = '{4'hF, 4'h2, 1'b0, 4'h1, 1'b1, 1'b0}; // -1 + 2
    vecs[1] = '{4'hF, 4'h9, 1'b0, 4'h8, 1'b1, 1'b0}; // -1 + -7
    vecs[2] = '{4'hB, 4'hC, 1'b0, 4'h7, 1'b1, 1'b1}; // -5 + -4
    vecs[3] = '{4'h2, 4'h7, 1'b0, 4'h9, 1'b0, 1'b1}; //  2 + 7
    vecs[4] = '{4'h2, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0}; //  2 - 3
    vecs[5] = '{4'h4, 4'hF, 1'b1, 4'h5, 1'b0, 1'b0}; //  4 - -1
    vecs[6] = '{4'hE, 4'h2, 1'b1, 4'hC, 1'b1, 1'b0}; // -2 - 2
    vecs[7] = '{4'hD, 4'h5, 1'b1, 4'h8, 1'b1, 1'b0}; // -3 - 5
    vecs[8] = '{4'h3, 4'h3, 1'b1, 4'h0, 1'b1, 1'b0}; //  3 - 3
    vecs[9] = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1}; // -8 - 1

    rst_n = 1'b0;
    a4 = '0; b4 = '0; m4 = 1'b0;
    a6 = '0; b6 = '0; m6 = 1'b0;

    #1;
    check("por.S4", 32'(s4), 32'h0);
    check("por.C4", 32'(c4), 32'h0);
    check("por.V4", 32'(v4), 32'h0);
    check("por.S6", 32'(s6), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a4 = vecs[i].a;
      b4 = vecs[i].b;
      m4 = vecs[i].m;
      @(negedge clk);
      check($sformatf("vec%0d.S", i), 32'(s4), 32'(vecs[i].s));
      check($sformatf("vec%0d.C", i), 32'(c4), 32'(vecs[i].c));
      check($sformatf("vec%0d.V", i), 32'(v4), 32'(vecs[i].v));
    end

    // 7 + 7 captures as -2 with overflow; mid-cycle input changes must not reach S.
    a4 = 4'h7; b4 = 4'h7; m4 = 1'b0;
    @(negedge clk);
    check("cap.S", 32'(s4), 32'hE);
    check("cap.C", 32'(c4), 32'h0);
    check("cap.V", 32'(v4), 32'h1);
    #2;
    a4 = 4'h1; b4 = 4'h1;
    #2;
    check("hold.S", 32'(s4), 32'hE);
    check("hold.V", 32'(v4), 32'h1);
    a4 = 4'h7; b4 = 4'h7;

    // Reset between edges clears immediately and holds across an edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.S", 32'(s4), 32'h0);
    check("rst.C", 32'(c4), 32'h0);
    check("rst.V", 32'(v4), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold.S", 32'(s4), 32'h0);
    check("rst_hold.V", 32'(v4), 32'h0);
    check("rst_hold.S6", 32'(s6), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.S", 32'(s4), 32'hE);
    check("rel.C", 32'(c4), 32'h0);
    check("rel.V", 32'(v4), 32'h1);

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          a4 = 4'(a); b4 = 4'(b); m4 = 1'(m);
          model(4, a, b, m, es, ec, ev);
          @(negedge clk);
          check($sformatf("w4 a=%0d b=%0d m=%0d S", a, b, m), 32'(s4), 32'(es));
          check($sformatf("w4 a=%0d b=%0d m=%0d C", a, b, m), 32'(c4), 32'(ec));
          check($sformatf("w4 a=%0d b=%0d m=%0d V", a, b, m), 32'(v4), 32'(ev));
        end
      end
    end

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 64; a++) begin
        for (int b = 0; b < 64; b++) begin
          a6 = 6'(a); b6 = 6'(b); m6 = 1'(m);
          model(6, a, b, m, es, ec, ev);
          @(negedge clk);
          check($sformatf("w6 a=%0d b=%0d m=%0d S", a, b, m), 32'(s6), 32'(es));
          check($sformatf("w6 a=%0d b=%0d m=%0d C", a, b, m), 32'(c6), 32'(ec));
          check($sformatf("w6 a=%0d b=%0d m=%0d V", a, b, m), 32'(v6), 32'(ev));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
